// File: rtl/leg4_progmem_if.sv
// Fetch port, load stream and status bundle between the loader/CPU side and leg4_progmem.
interface leg4_progmem_if;
  logic [3:0] adr;
  logic [7:0] mem;
  logic       cpu_nrst;
  logic       ld_start;
  logic       run;
  logic [7:0] ld_data;
  logic       ld_valid;
  logic       ld_ready;
  logic       busy;
  logic       err;

  modport slave (
    input  adr, ld_start, run, ld_data, ld_valid,
    output mem, cpu_nrst, ld_ready, busy, err
  );

  modport master (
    output adr, ld_start, run, ld_data, ld_valid,
    input  mem, cpu_nrst, ld_ready, busy, err
  );
endinterface

// File: rtl/leg4_progmem.sv
// 16x8 program RAM with byte-stream loader; fetch is combinational, loads use valid/ready (ready only while loading).
// Optional trailing checksum byte enabled by defining LEG4_PROGMEM_CHECKSUM_EN.
module leg4_progmem #(
  parameter int AUTORUN = 1
) (
  input logic            clk,
  input logic            nrst,
  leg4_progmem_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
`ifdef LEG4_PROGMEM_CHECKSUM_EN
    ST_CHECK = 2'd2,
`endif
    ST_RUN   = 2'd3
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] wptr;
  logic [3:0] wptr_nxt;
  logic       wr_en;

  // 2-state storage so the array comes up all-zero without a reset port
  bit [7:0]   ram [16];

`ifdef LEG4_PROGMEM_CHECKSUM_EN
  logic [7:0] sum;
  logic [7:0] sum_nxt;
  logic       err_q;
  logic       err_nxt;
`endif

  always_comb begin
    state_nxt = state;
    wptr_nxt  = wptr;
    wr_en     = 1'b0;
`ifdef LEG4_PROGMEM_CHECKSUM_EN
    sum_nxt   = sum;
    err_nxt   = err_q;
`endif
    case (state)
      ST_IDLE: begin
        if (bus.ld_start) begin
          state_nxt = ST_LOAD;
          wptr_nxt  = 4'd0;
`ifdef LEG4_PROGMEM_CHECKSUM_EN
          sum_nxt   = 8'd0;
          err_nxt   = 1'b0;
`endif
        end else if (bus.run) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (bus.ld_start) begin
          state_nxt = ST_LOAD;
          wptr_nxt  = 4'd0;
`ifdef LEG4_PROGMEM_CHECKSUM_EN
          sum_nxt   = 8'd0;
          err_nxt   = 1'b0;
`endif
        end
      end
      ST_LOAD: begin
        // a restart beats a byte offered in the same cycle
        if (bus.ld_start) begin
          wptr_nxt = 4'd0;
`ifdef LEG4_PROGMEM_CHECKSUM_EN
          sum_nxt  = 8'd0;
`endif
        end else if (bus.ld_valid) begin
          wr_en    = 1'b1;
          wptr_nxt = wptr + 4'd1;
`ifdef LEG4_PROGMEM_CHECKSUM_EN
          sum_nxt  = sum + bus.ld_data;
          if (wptr == 4'hF) begin
            state_nxt = ST_CHECK;
          end
`else
          if (wptr == 4'hF) begin
            state_nxt = (AUTORUN != 0) ? ST_RUN : ST_IDLE;
          end
`endif
        end
      end
`ifdef LEG4_PROGMEM_CHECKSUM_EN
      ST_CHECK: begin
        if (bus.ld_start) begin
          state_nxt = ST_LOAD;
          wptr_nxt  = 4'd0;
          sum_nxt   = 8'd0;
        end else if (bus.ld_valid) begin
          if (bus.ld_data == sum) begin
            err_nxt   = 1'b0;
            state_nxt = (AUTORUN != 0) ? ST_RUN : ST_IDLE;
          end else begin
            err_nxt   = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
      end
`endif
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state <= ST_IDLE;
      wptr  <= 4'd0;
`ifdef LEG4_PROGMEM_CHECKSUM_EN
      sum   <= 8'd0;
      err_q <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      wptr  <= wptr_nxt;
`ifdef LEG4_PROGMEM_CHECKSUM_EN
      sum   <= sum_nxt;
      err_q <= err_nxt;
`endif
    end
  end

  // reset aborts a load but never touches bytes already stored
  always_ff @(posedge clk) begin
    if (wr_en && nrst) begin
      ram[wptr] <= bus.ld_data;
    end
  end

  assign bus.mem      = ram[bus.adr];
  assign bus.cpu_nrst = (state == ST_RUN);
`ifdef LEG4_PROGMEM_CHECKSUM_EN
  assign bus.ld_ready = (state == ST_LOAD) || (state == ST_CHECK);
  assign bus.busy     = (state == ST_LOAD) || (state == ST_CHECK);
  assign bus.err      = err_q;
`else
  assign bus.ld_ready = (state == ST_LOAD);
  assign bus.busy     = (state == ST_LOAD);
  assign bus.err      = 1'b0;
`endif

endmodule

// File: tb/tb_leg4_progmem.sv
// Directed bench for leg4_progmem: reset, streaming loads, restart, mid-load reset, optional checksum.
module tb_leg4_progmem;
  logic clk = 1'b0;
  logic nrst;
  int   checks = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  leg4_progmem_if bus ();

  leg4_progmem #(.AUTORUN(1)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.ld_start = 1'b0;
    bus.run      = 1'b0;
    bus.ld_valid = 1'b0;
    bus.ld_data  = 8'h00;
    bus.adr      = 4'h0;
  endtask

  task automatic pulse_start();
    bus.ld_start = 1'b1;
    tick();
    bus.ld_start = 1'b0;
  endtask

  task automatic stream(input logic [7:0] base);
    for (int i = 0; i < 16; i++) begin
      bus.ld_valid = 1'b1;
      bus.ld_data  = base + 8'(i);
      tick();
    end
    bus.ld_valid = 1'b0;
  endtask

`ifdef LEG4_PROGMEM_CHECKSUM_EN
  task automatic send_trailer(input logic [7:0] s);
    bus.ld_valid = 1'b1;
    bus.ld_data  = s;
    tick();
    bus.ld_valid = 1'b0;
  endtask
`endif

  task automatic test_reset();
    nrst = 1'b0;
    idle_inputs();
    tick(); tick(); tick();
    nrst = 1'b1;
    checks++; if (bus.cpu_nrst !== 1'b0) $display("FAIL reset_cpu_nrst: got %b expected 0", bus.cpu_nrst); else passed++;
    checks++; if (bus.ld_ready !== 1'b0) $display("FAIL reset_ld_ready: got %b expected 0", bus.ld_ready); else passed++;
    checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", bus.busy); else passed++;
    checks++; if (bus.err !== 1'b0) $display("FAIL reset_err: got %b expected 0", bus.err); else passed++;
    for (int i = 0; i < 16; i++) begin
      bus.adr = 4'(i);
      #1;
      checks++; if (bus.mem !== 8'h00) $display("FAIL reset_mem[%0d]: got %h expected 00", i, bus.mem); else passed++;
    end
    // a byte offered in IDLE must not land in RAM
    bus.adr = 4'h0; bus.ld_valid = 1'b1; bus.ld_data = 8'h99;
    tick();
    bus.ld_valid = 1'b0;
    checks++; if (bus.mem !== 8'h00) $display("FAIL idle_valid_ignored: got %h expected 00", bus.mem); else passed++;
    checks++; if (bus.busy !== 1'b0) $display("FAIL idle_valid_busy: got %b expected 0", bus.busy); else passed++;
  endtask

  task automatic test_back_to_back();
    pulse_start();
    checks++; if (bus.busy !== 1'b1) $display("FAIL b2b_busy_load: got %b expected 1", bus.busy); else passed++;
    checks++; if (bus.ld_ready !== 1'b1) $display("FAIL b2b_ready_load: got %b expected 1", bus.ld_ready); else passed++;
    checks++; if (bus.cpu_nrst !== 1'b0) $display("FAIL b2b_cpu_nrst_load: got %b expected 0", bus.cpu_nrst); else passed++;
    for (int i = 0; i < 16; i++) begin
      bus.ld_valid = 1'b1;
      bus.ld_data  = 8'h10 + 8'(i);
      tick();
      if (i == 14) begin
        checks++; if (bus.busy !== 1'b1) $display("FAIL b2b_busy_after15: got %b expected 1", bus.busy); else passed++;
      end
    end
    bus.ld_valid = 1'b0;
`ifdef LEG4_PROGMEM_CHECKSUM_EN
    send_trailer(8'h78);
`endif
    checks++; if (bus.cpu_nrst !== 1'b1) $display("FAIL b2b_cpu_nrst_run: got %b expected 1", bus.cpu_nrst); else passed++;
    checks++; if (bus.busy !== 1'b0) $display("FAIL b2b_busy_run: got %b expected 0", bus.busy); else passed++;
    checks++; if (bus.ld_ready !== 1'b0) $display("FAIL b2b_ready_run: got %b expected 0", bus.ld_ready); else passed++;
    checks++; if (bus.err !== 1'b0) $display("FAIL b2b_err: got %b expected 0", bus.err); else passed++;
    bus.adr = 4'h5;
    #1;
    checks++; if (bus.mem !== 8'h15) $display("FAIL b2b_mem5: got %h expected 15", bus.mem); else passed++;
  endtask

  task automatic test_valid_toggle();
    logic [7:0] exp;
    pulse_start();
    checks++; if (bus.cpu_nrst !== 1'b0) $display("FAIL tog_cpu_nrst_falls: got %b expected 0", bus.cpu_nrst); else passed++;
    for (int k = 0; k < 32; k++) begin
      if ((k % 2) == 0) begin
        bus.ld_valid = 1'b1;
        bus.ld_data  = 8'h10 + 8'(k / 2);
      end else begin
        bus.ld_valid = 1'b0;
        bus.ld_data  = 8'hEE;
      end
      tick();
      if (k == 29) begin
        checks++; if (bus.busy !== 1'b1) $display("FAIL tog_busy_after15: got %b expected 1", bus.busy); else passed++;
      end
    end
    bus.ld_valid = 1'b0;
`ifdef LEG4_PROGMEM_CHECKSUM_EN
    send_trailer(8'h78);
`endif
    checks++; if (bus.cpu_nrst !== 1'b1) $display("FAIL tog_cpu_nrst_run: got %b expected 1", bus.cpu_nrst); else passed++;
    for (int i = 0; i < 16; i++) begin
      bus.adr = 4'(i);
      exp = 8'h10 + 8'(i);
      #1;
      checks++; if (bus.mem !== exp) $display("FAIL tog_mem[%0d]: got %h expected %h", i, bus.mem, exp); else passed++;
    end
  endtask

  task automatic test_restart_collision();
    logic [7:0] exp;
    pulse_start();
    for (int i = 0; i < 8; i++) begin
      bus.ld_valid = 1'b1;
      bus.ld_data  = 8'h50 + 8'(i);
      tick();
    end
    bus.ld_start = 1'b1; bus.ld_valid = 1'b1; bus.ld_data = 8'h58;
    tick();
    bus.ld_start = 1'b0; bus.ld_valid = 1'b0;
    bus.adr = 4'h8;
    #1;
    checks++; if (bus.mem !== 8'h18) $display("FAIL col_mem8_untouched: got %h expected 18", bus.mem); else passed++;
    bus.adr = 4'h0;
    #1;
    checks++; if (bus.mem !== 8'h50) $display("FAIL col_mem0_partial: got %h expected 50", bus.mem); else passed++;
    checks++; if (bus.busy !== 1'b1) $display("FAIL col_busy: got %b expected 1", bus.busy); else passed++;
    stream(8'hA0);
`ifdef LEG4_PROGMEM_CHECKSUM_EN
    send_trailer(8'h78);
`endif
    checks++; if (bus.cpu_nrst !== 1'b1) $display("FAIL col_cpu_nrst_run: got %b expected 1", bus.cpu_nrst); else passed++;
    for (int i = 0; i < 16; i++) begin
      bus.adr = 4'(i);
      exp = 8'hA0 + 8'(i);
      #1;
      checks++; if (bus.mem !== exp) $display("FAIL col_mem[%0d]: got %h expected %h", i, bus.mem, exp); else passed++;
    end
  endtask

  task automatic test_reset_mid_load();
    logic [7:0] exp;
    pulse_start();
    checks++; if (bus.cpu_nrst !== 1'b0) $display("FAIL rml_cpu_nrst_load: got %b expected 0", bus.cpu_nrst); else passed++;
    for (int i = 0; i < 4; i++) begin
      bus.ld_valid = 1'b1;
      bus.ld_data  = 8'hC0 + 8'(i);
      tick();
    end
    nrst = 1'b0; bus.ld_valid = 1'b1; bus.ld_data = 8'hC4;
    tick();
    nrst = 1'b1; bus.ld_valid = 1'b0;
    checks++; if (bus.busy !== 1'b0) $display("FAIL rml_busy: got %b expected 0", bus.busy); else passed++;
    checks++; if (bus.ld_ready !== 1'b0) $display("FAIL rml_ready: got %b expected 0", bus.ld_ready); else passed++;
    checks++; if (bus.cpu_nrst !== 1'b0) $display("FAIL rml_cpu_nrst: got %b expected 0", bus.cpu_nrst); else passed++;
    for (int i = 0; i < 16; i++) begin
      bus.adr = 4'(i);
      exp = (i < 4) ? (8'hC0 + 8'(i)) : (8'hA0 + 8'(i));
      #1;
      checks++; if (bus.mem !== exp) $display("FAIL rml_mem[%0d]: got %h expected %h", i, bus.mem, exp); else passed++;
    end
    tick();
    checks++; if (bus.cpu_nrst !== 1'b0) $display("FAIL rml_stays_idle: got %b expected 0", bus.cpu_nrst); else passed++;
    bus.run = 1'b1;
    tick();
    bus.run = 1'b0;
    checks++; if (bus.cpu_nrst !== 1'b1) $display("FAIL run_pulse: got %b expected 1", bus.cpu_nrst); else passed++;
    // bytes, run pulses and fetch traffic while running change nothing
    bus.run = 1'b1; bus.ld_valid = 1'b1; bus.ld_data = 8'h77;
    for (int i = 0; i < 4; i++) begin
      bus.adr = 4'(3 * i);
      tick();
    end
    bus.run = 1'b0; bus.ld_valid = 1'b0; bus.adr = 4'h0;
    #1;
    checks++; if (bus.cpu_nrst !== 1'b1) $display("FAIL run_held: got %b expected 1", bus.cpu_nrst); else passed++;
    checks++; if (bus.mem !== 8'hC0) $display("FAIL run_no_write: got %h expected c0", bus.mem); else passed++;
  endtask

  task automatic test_idle_priority();
    nrst = 1'b0;
    tick();
    nrst = 1'b1;
    bus.ld_start = 1'b1; bus.run = 1'b1;
    tick();
    bus.ld_start = 1'b0; bus.run = 1'b0;
    checks++; if (bus.busy !== 1'b1) $display("FAIL prio_busy: got %b expected 1", bus.busy); else passed++;
    checks++; if (bus.cpu_nrst !== 1'b0) $display("FAIL prio_cpu_nrst: got %b expected 0", bus.cpu_nrst); else passed++;
  endtask

`ifdef LEG4_PROGMEM_CHECKSUM_EN
  task automatic test_checksum();
    pulse_start();
    for (int i = 0; i < 16; i++) begin
      bus.ld_valid = 1'b1; bus.ld_data = 8'h01;
      tick();
    end
    bus.ld_valid = 1'b0;
    checks++; if (bus.ld_ready !== 1'b1) $display("FAIL cs_ready_check: got %b expected 1", bus.ld_ready); else passed++;
    checks++; if (bus.busy !== 1'b1) $display("FAIL cs_busy_check: got %b expected 1", bus.busy); else passed++;
    send_trailer(8'h10);
    checks++; if (bus.cpu_nrst !== 1'b1) $display("FAIL cs_good_run: got %b expected 1", bus.cpu_nrst); else passed++;
    checks++; if (bus.err !== 1'b0) $display("FAIL cs_good_err: got %b expected 0", bus.err); else passed++;
    pulse_start();
    for (int i = 0; i < 16; i++) begin
      bus.ld_valid = 1'b1; bus.ld_data = 8'h01;
      tick();
    end
    send_trailer(8'h11);
    checks++; if (bus.err !== 1'b1) $display("FAIL cs_bad_err: got %b expected 1", bus.err); else passed++;
    checks++; if (bus.cpu_nrst !== 1'b0) $display("FAIL cs_bad_cpu_nrst: got %b expected 0", bus.cpu_nrst); else passed++;
    checks++; if (bus.busy !== 1'b0) $display("FAIL cs_bad_busy: got %b expected 0", bus.busy); else passed++;
  endtask
`endif

  initial begin
    nrst = 1'b0;
    idle_inputs();
    test_reset();
    test_back_to_back();
    test_valid_toggle();
    test_restart_collision();
    test_reset_mid_load();
    test_idle_priority();
`ifdef LEG4_PROGMEM_CHECKSUM_EN
    test_checksum();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
